// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters gated by an enable
// handshake that only stops on a frame boundary, decoded into registered
// pixel coordinates, data enable, syncs and start-of-frame/line strobes.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        enable,
  output logic        busy,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic        pixel_de,
  output logic        pixel_hs,
  output logic        pixel_vs,
  output logic        frame_start,
  output logic        line_start
);

  localparam int unsigned CNT_W   = 12;
  localparam int unsigned CMP_W   = CNT_W + 1;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Comparisons are done one bit wider so boundaries equal to 4096 stay exact.
  localparam logic [CMP_W-1:0] H_ACT_END  = CMP_W'(H_ACTIVE);
  localparam logic [CMP_W-1:0] H_SYN_BEG  = CMP_W'(H_ACTIVE + H_FP);
  localparam logic [CMP_W-1:0] H_SYN_END  = CMP_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CMP_W-1:0] V_ACT_END  = CMP_W'(V_ACTIVE);
  localparam logic [CMP_W-1:0] V_SYN_BEG  = CMP_W'(V_ACTIVE + V_FP);
  localparam logic [CMP_W-1:0] V_SYN_END  = CMP_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);

  // Totals must fit the 12-bit counters.
  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_check
    $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 12-bit counter range");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_STOP_PEND = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             frame_last;
  logic             de_c;
  logic             v_act_c;
  logic             hs_on_c;
  logic             vs_on_c;

  assign frame_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // State register.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a stop request is only honoured on the last cycle of a frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RUN;
      end
      S_RUN: begin
        if (!enable) state_d = S_STOP_PEND;
      end
      S_STOP_PEND: begin
        if (enable) begin
          state_d = S_RUN;
        end else if (frame_last) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Raster counters: held at zero when idle, otherwise advance and wrap.
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst || state_q == S_IDLE) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Position decode of the current counter values.
  always_comb begin
    de_c    = ({1'b0, h_cnt} < H_ACT_END) && ({1'b0, v_cnt} < V_ACT_END);
    v_act_c = ({1'b0, v_cnt} < V_ACT_END);
    hs_on_c = ({1'b0, h_cnt} >= H_SYN_BEG) && ({1'b0, h_cnt} < H_SYN_END);
    vs_on_c = ({1'b0, v_cnt} >= V_SYN_BEG) && ({1'b0, v_cnt} < V_SYN_END);
  end

  // Single output register stage; idle state is forced rather than decoding (0,0).
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst || state_q == S_IDLE) begin
      busy        <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_de    <= 1'b0;
      pixel_hs    <= ~HS_POL;
      pixel_vs    <= ~VS_POL;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      busy        <= 1'b1;
      pixel_x     <= de_c ? h_cnt : '0;
      pixel_y     <= v_act_c ? v_cnt : '0;
      pixel_de    <= de_c;
      pixel_hs    <= hs_on_c ? HS_POL : ~HS_POL;
      pixel_vs    <= vs_on_c ? VS_POL : ~VS_POL;
      frame_start <= de_c && (h_cnt == '0) && (v_cnt == '0);
      line_start  <= de_c && (h_cnt == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two instances (positive and negative sync
// polarity) on a small raster, a frame-position reference model compared
// every cycle, directed start/stop/reset scenarios and random enable traffic.
module tb_video_timing_gen;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 1;
  localparam int VA = 4;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;

  logic        busy_a, de_a, hs_a, vs_a, fs_a, ls_a;
  logic [11:0] x_a, y_a;
  logic        busy_b, de_b, hs_b, vs_b, fs_b, ls_b;
  logic [11:0] x_b, y_b;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_dut_pos (
    .pixel_clk(clk), .pixel_rst(rst), .enable(en), .busy(busy_a),
    .pixel_x(x_a), .pixel_y(y_a), .pixel_de(de_a), .pixel_hs(hs_a),
    .pixel_vs(vs_a), .frame_start(fs_a), .line_start(ls_a)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut_neg (
    .pixel_clk(clk), .pixel_rst(rst), .enable(en), .busy(busy_b),
    .pixel_x(x_b), .pixel_y(y_b), .pixel_de(de_b), .pixel_hs(hs_b),
    .pixel_vs(vs_b), .frame_start(fs_b), .line_start(ls_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Expected output word for a generator either idle or at frame position p.
  function automatic logic [29:0] exp_vec(input bit run, input int p,
                                          input bit hpol, input bit vpol);
    int h;
    int v;
    bit de;
    bit hs;
    bit vs;
    if (!run) return {1'b0, 12'd0, 12'd0, 1'b0, ~hpol, ~vpol, 1'b0, 1'b0};
    h  = p % HT;
    v  = p / HT;
    de = (h < HA) && (v < VA);
    hs = (h >= HA + HF && h < HA + HF + HS) ? hpol : ~hpol;
    vs = (v >= VA + VF && v < VA + VF + VS) ? vpol : ~vpol;
    return {1'b1, de ? 12'(h) : 12'd0, (v < VA) ? 12'(v) : 12'd0,
            de, hs, vs, de && (p == 0), de && (h == 0)};
  endfunction

  // Reference model: running flag, stop-requested flag and frame position.
  bit          m_run   = 1'b0;
  bit          m_stop  = 1'b0;
  bit          m_valid = 1'b0;
  int          m_p     = 0;
  logic [29:0] exp_a;
  logic [29:0] exp_b;

  always @(posedge clk) begin
    if (rst) begin
      exp_a   = exp_vec(1'b0, 0, 1'b1, 1'b1);
      exp_b   = exp_vec(1'b0, 0, 1'b0, 1'b0);
      m_run   = 1'b0;
      m_stop  = 1'b0;
      m_p     = 0;
      m_valid = 1'b1;
    end else begin
      exp_a = exp_vec(m_run, m_p, 1'b1, 1'b1);
      exp_b = exp_vec(m_run, m_p, 1'b0, 1'b0);
      if (!m_run) begin
        m_run  = en;
        m_stop = 1'b0;
        m_p    = 0;
      end else if (en) begin
        m_stop = 1'b0;
        m_p    = (m_p + 1) % FR;
      end else if (m_stop && m_p == FR - 1) begin
        m_run  = 1'b0;
        m_stop = 1'b0;
        m_p    = 0;
      end else begin
        m_stop = 1'b1;
        m_p    = (m_p + 1) % FR;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [29:0] act_a;
    logic [29:0] act_b;
    if (m_valid) begin
      act_a = {busy_a, x_a, y_a, de_a, hs_a, vs_a, fs_a, ls_a};
      act_b = {busy_b, x_b, y_b, de_b, hs_b, vs_b, fs_b, ls_b};
      n_chk++;
      if (act_a === exp_a) n_pass++;
      else $display("FAIL model_pos @%0t: got %h, expected %h", $time, act_a, exp_a);
      n_chk++;
      if (act_b === exp_b) n_pass++;
      else $display("FAIL model_neg @%0t: got %h, expected %h", $time, act_b, exp_b);
    end
  end

  // Waits for the next frame_start; n is the number of falling edges waited.
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs_a && n < 400);
  endtask

  // Collects one frame of output statistics starting at a frame_start sample.
  task automatic frame_stats();
    int   dec      = 0;
    int   hsa      = 0;
    int   hsb      = 0;
    int   vsc      = 0;
    int   vs_first = -1;
    int   lsc      = 0;
    int   last_ls  = 0;
    logic prev_hs  = 1'b0;
    for (int i = 0; i < FR; i++) begin
      if (i > 0) @(negedge clk);
      dec += int'(de_a);
      hsa += int'(hs_a);
      hsb += int'(!hs_b);
      vsc += int'(vs_a);
      if (vs_a && vs_first < 0) vs_first = i;
      if (ls_a) begin
        chk("line_y", int'(y_a), lsc);
        lsc++;
        last_ls = i;
      end
      if (hs_a && !prev_hs && (i / HT) < VA) chk("hs_offset", i - last_ls, 10);
      prev_hs = hs_a;
    end
    chk("de_per_frame", dec, 32);
    chk("hs_pos_cycles", hsa, 24);
    chk("hs_neg_low_cycles", hsb, 24);
    chk("vs_cycles", vsc, 28);
    chk("vs_first_cycle", vs_first, 70);
    chk("lines_per_frame", lsc, 4);
    @(negedge clk);
    chk("frame_period_fs", int'(fs_a), 1);
  endtask

  initial begin
    int lat;
    int idx;
    int fsc;

    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_hs_neg", int'(hs_b), 1);
    chk("reset_vs_pos", int'(vs_a), 0);
    rst = 1'b0;
    @(negedge clk);

    // Start latency and frame structure.
    en = 1'b1;
    wait_fs(lat);
    chk("start_latency", lat, 2);
    chk("start_x", int'(x_a), 0);
    frame_stats();

    // Graceful stop mid-frame.
    for (int i = 1; i <= 50; i++) @(negedge clk);
    en  = 1'b0;
    idx = 50;
    while (busy_a && idx < 400) begin
      @(negedge clk);
      idx++;
    end
    chk("stop_busy_fall", idx, 112);
    fsc = 0;
    repeat (150) begin
      @(negedge clk);
      fsc += int'(fs_a);
    end
    chk("no_fs_after_stop", fsc, 0);
    chk("idle_hs_pos", int'(hs_a), 0);
    chk("idle_hs_neg", int'(hs_b), 1);

    // Stop request cancelled before the frame ends.
    en = 1'b1;
    wait_fs(lat);
    chk("restart_latency", lat, 2);
    idx = 0;
    while (idx < 300) begin
      @(negedge clk);
      idx++;
      if (idx == 40) en = 1'b0;
      if (idx == 60) en = 1'b1;
      if (fs_a) break;
    end
    chk("cancel_gap", idx, 112);

    // Enable drops just before the final frame cycle and returns on it.
    idx = 0;
    while (idx < 300) begin
      @(negedge clk);
      idx++;
      if (idx == 109) en = 1'b0;
      if (idx == 110) en = 1'b1;
      if (fs_a) break;
    end
    chk("boundary_gap", idx, 112);

    // Mid-frame reset with enable held high.
    for (int i = 1; i <= 70; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_de", int'(de_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_hs_pos", int'(hs_a), 0);
    chk("rst_hs_neg", int'(hs_b), 1);
    rst = 1'b0;
    wait_fs(lat);
    chk("rst_release_latency", lat, 2);
    chk("rst_release_x", int'(x_a), 0);

    // Random enable traffic with occasional resets.
    repeat (30) begin
      en = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 250)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    // Drain to idle.
    en  = 1'b0;
    idx = 0;
    while (busy_a && idx < 300) begin
      @(negedge clk);
      idx++;
    end
    @(negedge clk);
    chk("final_idle_busy", int'(busy_a), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
